mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: memory word-address width.
REQ-002 Parameter DATA_W, default 16: memory word width.
REQ-003 Parameter RD_LAT, default 1, legal range 1..7: cycles from mem_en (read) to mem_rdata valid.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-006 if_req/dm_req/ld_req  input  1 each  access request from fetch (0), data (1) and loader (2).
REQ-007 dm_we, ld_we  input  1 each  write enable for the data and loader requesters; fetch is read-only.
REQ-008 if_addr/dm_addr/ld_addr  input  ADDR_W each  request address.
REQ-009 dm_wdata, ld_wdata  input  DATA_W each  write data.
REQ-010 if_valid/dm_valid/ld_valid  output  1 each  one-cycle completion pulse per requester.
REQ-011 rdata  output  DATA_W  read data shared by all requesters; meaningful only when a valid pulse is high.
REQ-012 mem_en, mem_we  output  1 each  single-port RAM strobe and write enable.
REQ-013 mem_addr, mem_wdata  output  ADDR_W, DATA_W  RAM address and write data.
REQ-014 mem_rdata  input  DATA_W  RAM read data.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-017 Requests are level: a requester holds req and all its operands stable until it sees its valid pulse, then drops req in the following cycle or issues a new request.
REQ-018 IDLE with at least one req high: grant one requester round-robin and go to ISSUE.
- Search starts at the index after the last-granted requester, in order 0 -> 1 -> 2 -> 0.
- The last-granted pointer resets to 2, so fetch wins the first contest after reset.
REQ-019 IDLE with no req high: remain in IDLE; mem_en = 0.
REQ-020 ISSUE lasts exactly one cycle.
- mem_en = 1.
- mem_addr, mem_we and mem_wdata are driven from the granted requester; mem_we is 0 for fetch.
REQ-021 ISSUE, write grant: go to RESP.
REQ-022 ISSUE, read grant: go to WAIT with the latency counter loaded to RD_LAT-1.
REQ-023 WAIT: while the counter is nonzero, decrement it and stay.
- When the counter is 0, register mem_rdata into rdata and go to RESP.
- With RD_LAT = 1, WAIT lasts exactly one cycle.
REQ-024 RESP lasts exactly one cycle.
- Assert only the granted requester's valid.
- Update the last-granted pointer.
- Return to IDLE.
REQ-025 Outside ISSUE: mem_en = 0, mem_we = 0, mem_addr and mem_wdata hold their last values.
REQ-026 At most one valid is high in any cycle, and valid is never high outside RESP.
REQ-027 Latency from grant: write = 3 cycles; read = 3 + RD_LAT cycles, measured from req seen in IDLE to the valid cycle inclusive.
REQ-028 Requests raised or dropped while busy do not affect the current transaction.
- They are considered only at the next IDLE evaluation.
- A req withdrawn before its grant is simply not granted.
REQ-029 rdata holds its value until the next read capture; on write completion rdata is unchanged.
REQ-030 All three requests arriving in the same cycle: grant per REQ-018; the remaining two are served in round-robin order on subsequent IDLE visits, so no requester waits more than two other transactions.

Reset
REQ-031 While reset = 0 at a clock edge, all of the following SHALL take effect on that edge:
- state <= IDLE, counter <= 0, last-granted pointer <= 2.
- All valid outputs, mem_en, mem_we and busy <= 0.
- mem_addr, mem_wdata and rdata <= 0.
REQ-032 Reset asserted mid-transaction (ISSUE, WAIT or RESP) aborts it.
- No valid pulse is issued for the aborted request.
- No further mem_en is issued until a fresh grant after reset is released.
REQ-033 On the first edge with reset = 1, evaluation starts from IDLE.

Verification
REQ-034 RD_LAT=1; if_req with if_addr=0x010 and mem returning 0xBEEF -> one mem_en at addr 0x010, if_valid pulses exactly once 4 cycles after req is sampled, rdata = 0xBEEF.
REQ-035 dm write, dm_addr=0x020, dm_wdata=0x1234 -> one cycle with mem_en=1, mem_we=1, mem_addr=0x020, mem_wdata=0x1234; dm_valid pulses 3 cycles after req; rdata unchanged.
REQ-036 All three reqs high from reset release, held until their own valid -> grant order fetch, data, loader, then fetch again; never two valids in one cycle.
REQ-037 RD_LAT=4, loader read -> WAIT lasts 4 cycles; ld_valid occurs 7 cycles after req; busy stays high throughout.
REQ-038 reset driven low during WAIT of a fetch read -> no if_valid; next cycle all outputs are 0 and state is IDLE; a new dm_req after release is granted first only if if_req is low.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter that multiplexes three requesters (fetch = 0,
//   data = 1, loader = 2) onto one single-port RAM. One transaction is in
//   flight at a time: IDLE -> ISSUE -> [WAIT] -> RESP -> IDLE.
//
// Ports
//   clock                      rising-edge clock
//   reset                      synchronous, active-low reset
//   if_req/dm_req/ld_req       level requests, held until the matching valid
//   dm_we, ld_we               write enables (fetch is read-only)
//   if_addr/dm_addr/ld_addr    request word addresses
//   dm_wdata, ld_wdata         write data
//   if_valid/dm_valid/ld_valid one-cycle completion pulses
//   rdata                      read data, meaningful while a valid is high
//   mem_en, mem_we             RAM strobe / write enable (ISSUE only)
//   mem_addr, mem_wdata        RAM address / write data (held outside ISSUE)
//   mem_rdata                  RAM read data, valid RD_LAT cycles after mem_en
//   busy                       high whenever the FSM is not in IDLE
//
// RD_LAT must lie in 1..7; the latency counter is three bits wide.

module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic              dm_req,
  input  logic              ld_req,
  input  logic              dm_we,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              if_valid,
  output logic              dm_valid,
  output logic              ld_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_cnt;
  logic [1:0]        r_last;
  logic [1:0]        r_grant;
  logic              r_grant_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic [2:0]        w_req;
  logic [1:0]        w_cand [3];
  logic              w_found;
  logic [1:0]        w_pick;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_we;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [2:0]        w_valid;
  logic              w_mem_en;
  logic              w_mem_we;
  logic              w_busy;

  // Successor in the cyclic order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] f_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  assign w_req = {ld_req, dm_req, if_req};

  // Search order starts just after the last-granted requester.
  assign w_cand[0] = f_next(r_last);
  assign w_cand[1] = f_next(w_cand[0]);
  assign w_cand[2] = f_next(w_cand[1]);

  always_comb begin
    w_found = 1'b0;
    w_pick  = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!w_found && w_req[w_cand[k]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[k];
      end
    end
  end

  // Operands of the requester about to be granted.
  always_comb begin
    w_sel_addr  = if_addr;
    w_sel_we    = 1'b0;
    w_sel_wdata = '0;
    case (w_pick)
      2'd1: begin
        w_sel_addr  = dm_addr;
        w_sel_we    = dm_we;
        w_sel_wdata = dm_wdata;
      end
      2'd2: begin
        w_sel_addr  = ld_addr;
        w_sel_we    = ld_we;
        w_sel_wdata = ld_wdata;
      end
      default: ;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = r_grant_we ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 3'd0) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from the current state
  always_comb begin
    w_mem_en = (r_state == S_ISSUE);
    w_mem_we = (r_state == S_ISSUE) && r_grant_we;
    w_busy   = (r_state != S_IDLE);
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_valid
    assign w_valid[gi] = (r_state == S_RESP) && (r_grant == 2'(gi));
  end

  // Datapath: grant latch, latency counter, read capture, RR pointer.
  // Operands are latched at the grant edge so requester changes during
  // the transaction cannot disturb it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt       <= 3'd0;
      r_last      <= 2'd2;
      r_grant     <= 2'd0;
      r_grant_we  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_pick;
            r_grant_we  <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
          end
        end
        S_ISSUE: begin
          if (!r_grant_we) r_cnt <= LAT_LOAD;
        end
        S_WAIT: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            r_rdata <= mem_rdata;
          end
        end
        S_RESP: begin
          r_last <= r_grant;
        end
        default: ;
      endcase
    end
  end

  assign if_valid  = w_valid[0];
  assign dm_valid  = w_valid[1];
  assign ld_valid  = w_valid[2];
  assign rdata     = r_rdata;
  assign mem_en    = w_mem_en;
  assign mem_we    = w_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = w_busy;

endmodule
